// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve countdown, rally, point freeze, pause and game over.
// Tracks the authoritative score and the hit-driven speed boost for the ball block.
module pong_match_ctrl #(
    parameter int         WIN_SCORE      = 7,
    parameter int         SERVE_DELAY    = 60,
    parameter int         POINT_DELAY    = 45,
    parameter int         HITS_PER_LEVEL = 4,
    parameter int         MAX_EXTRA      = 6,
    parameter logic [7:0] KEY_START      = 8'd40,
    parameter logic [7:0] KEY_PAUSE      = 8'd19
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       point_left,
    input  logic       point_right,
    input  logic       paddle1_hit,
    input  logic       paddle2_hit,
    output logic       ball_run,
    output logic       ball_hold,
    output logic       serve_dir,
    output logic [3:0] speed_extra,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SERVE  = 3'd1,
        S_RALLY  = 3'd2,
        S_POINT  = 3'd3,
        S_PAUSED = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    localparam int TMAX = (SERVE_DELAY > POINT_DELAY) ? SERVE_DELAY : POINT_DELAY;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam int HW   = (HITS_PER_LEVEL > 2) ? $clog2(HITS_PER_LEVEL) : 1;

    localparam logic [TW-1:0] SERVE_LOAD = TW'(SERVE_DELAY - 1);
    localparam logic [TW-1:0] POINT_LOAD = TW'(POINT_DELAY - 1);
    localparam logic [HW-1:0] HIT_LAST   = HW'(HITS_PER_LEVEL - 1);
    localparam logic [3:0]    WIN_Q      = 4'(WIN_SCORE);
    localparam logic [3:0]    MAX_Q      = 4'(MAX_EXTRA);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [HW-1:0] hit_cnt_q, hit_cnt_d;
    logic [7:0]    key_prev_q, key_prev_d;
    logic [3:0]    speed_q, speed_d;
    logic [3:0]    score_l_q, score_l_d;
    logic [3:0]    score_r_q, score_r_d;
    logic          serve_dir_q, serve_dir_d;
    logic          winner_q, winner_d;
    logic          game_over_q, game_over_d;
    logic          ball_run_q, ball_run_d;
    logic          ball_hold_q, ball_hold_d;

    logic       start_press, pause_press, any_hit;
    logic [3:0] new_score;

    assign start_press = (keycode == KEY_START) && (key_prev_q != KEY_START);
    assign pause_press = (keycode == KEY_PAUSE) && (key_prev_q != KEY_PAUSE);
    assign any_hit     = paddle1_hit | paddle2_hit;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        hit_cnt_d   = hit_cnt_q;
        key_prev_d  = keycode;
        speed_d     = speed_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        new_score   = point_left ? (score_l_q + 4'd1) : (score_r_q + 4'd1);

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_press) begin
                    state_d     = S_SERVE;
                    timer_d     = SERVE_LOAD;
                    hit_cnt_d   = '0;
                    speed_d     = '0;
                    score_l_d   = '0;
                    score_r_d   = '0;
                    serve_dir_d = 1'b0;
                end
            end
            S_SERVE: begin
                if (timer_q == '0) state_d = S_RALLY;
                else               timer_d = timer_q - 1'b1;
            end
            S_RALLY: begin
                if (point_left || point_right) begin
                    // A point swallows any hit and pause press arriving in the same frame.
                    speed_d     = '0;
                    hit_cnt_d   = '0;
                    serve_dir_d = point_left;
                    if (point_left) score_l_d = new_score;
                    else            score_r_d = new_score;
                    if (new_score == WIN_Q) begin
                        state_d  = S_OVER;
                        winner_d = !point_left;
                    end else begin
                        state_d = S_POINT;
                        timer_d = POINT_LOAD;
                    end
                end else begin
                    if (any_hit) begin
                        if (hit_cnt_q == HIT_LAST) begin
                            hit_cnt_d = '0;
                            if (speed_q != MAX_Q) speed_d = speed_q + 4'd1;
                        end else begin
                            hit_cnt_d = hit_cnt_q + 1'b1;
                        end
                    end
                    if (pause_press) state_d = S_PAUSED;
                end
            end
            S_POINT: begin
                if (timer_q == '0) begin
                    state_d = S_SERVE;
                    timer_d = SERVE_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_PAUSED: begin
                if (pause_press)      state_d = S_RALLY;
                else if (start_press) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        ball_run_d  = (state_d == S_RALLY);
        ball_hold_d = (state_d == S_IDLE) || (state_d == S_SERVE) || (state_d == S_OVER);
        game_over_d = (state_d == S_OVER);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            hit_cnt_q   <= '0;
            key_prev_q  <= '0;
            speed_q     <= '0;
            score_l_q   <= '0;
            score_r_q   <= '0;
            serve_dir_q <= 1'b0;
            winner_q    <= 1'b0;
            game_over_q <= 1'b0;
            ball_run_q  <= 1'b0;
            ball_hold_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            hit_cnt_q   <= hit_cnt_d;
            key_prev_q  <= key_prev_d;
            speed_q     <= speed_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            serve_dir_q <= serve_dir_d;
            winner_q    <= winner_d;
            game_over_q <= game_over_d;
            ball_run_q  <= ball_run_d;
            ball_hold_q <= ball_hold_d;
        end
    end

    assign ball_run    = ball_run_q;
    assign ball_hold   = ball_hold_q;
    assign serve_dir   = serve_dir_q;
    assign speed_extra = speed_q;
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;
    assign state_o     = state_q;

endmodule
